// File: rtl/sdram_pkg.sv
// SDRAM command encodings and arbiter state type shared by the arbiter and its bench.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter.sv
// SDRAM pin-bus owner: passes init traffic through, then grants the bus to
// refresh, write or read engines with refresh first and write/read alternating.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = SDRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_done,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_done,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_ba,
  input  logic              wr_done,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_ba,
  input  logic              rd_done,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              arb_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_wr_q, last_wr_d;
  logic             err_q, err_d;
  logic             aref_en_q, aref_en_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic             cke_q;
  logic             grant_done;

  always_comb begin
    grant_done = 1'b0;
    case (state_q)
      ST_AREF:  grant_done = aref_done;
      ST_WRITE: grant_done = wr_done;
      ST_READ:  grant_done = rd_done;
      default:  grant_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    last_wr_d = last_wr_q;
    err_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_done) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_d = ST_AREF;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = ST_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = ST_READ;
          last_wr_d = 1'b0;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // A done arriving on the final count still counts as a clean release.
        if (grant_done) begin
          state_d = ST_ARBIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ARBIT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    aref_en_d = (state_d == ST_AREF);
    wr_en_d   = (state_d == ST_WRITE);
    rd_en_d   = (state_d == ST_READ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cke_q     <= 1'b1;
    end
  end

  // Engines register their own outputs, so the pin mux adds no latency.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = 2'b00;
    case (state_q)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = 2'b00;
      end
    endcase
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign arb_err   = err_q;
  assign sdram_cke = cke_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a short grant timeout.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int ADDR_W  = 13;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              init_done;
  logic              aref_req, aref_done;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req, wr_done;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_ba;
  logic              rd_req, rd_done;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_ba;
  logic              aref_en, wr_en, rd_en, sdram_cke, arb_err;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [1:0]        sdram_ba;

  int n_checks;
  int n_fail;

  sdram_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_done(init_done),
    .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_done(aref_done),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_done(wr_done),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba), .rd_done(rd_done),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_ba(sdram_ba), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Packs grants as {aref_en, wr_en, rd_en} for compact checks.
  function automatic logic [31:0] grants();
    return {29'd0, aref_en, wr_en, rd_en};
  endfunction

  task automatic chk_nop(input string tag);
    check({tag, "_cmd"}, {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
    check({tag, "_en"}, grants(), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    init_cmd  = CMD_PALL;  init_addr = 13'h0400; init_done = 1'b0;
    aref_req  = 1'b0; aref_done = 1'b0; aref_cmd = CMD_AREF; aref_addr = 13'h00AA;
    wr_req    = 1'b0; wr_done   = 1'b0; wr_cmd   = CMD_WR;   wr_addr   = 13'h0111; wr_ba = 2'd1;
    rd_req    = 1'b0; rd_done   = 1'b0; rd_cmd   = CMD_RD;   rd_addr   = 13'h0222; rd_ba = 2'd2;

    #12;
    check("rst_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_PALL});
    check("rst_en", grants(), 32'd0);
    check("rst_cke", {31'd0, sdram_cke}, 32'd1);
    check("rst_err", {31'd0, arb_err}, 32'd0);

    // Test 1: init pass-through, requests ignored.
    @(negedge clk);
    rst_n  = 1'b1;
    wr_req = 1'b1;
    step();
    step();
    check("init_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_PALL});
    check("init_addr", {19'd0, sdram_addr}, 32'h0400);
    check("init_en", grants(), 32'd0);
    wr_req    = 1'b0;
    init_done = 1'b1;
    step();
    chk_nop("arbit0");
    check("arbit0_addr", {19'd0, sdram_addr}, 32'd0);

    // Test 2/3: refresh first, then write/read alternation.
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    check("t2_aref_en", grants(), 32'b100);
    check("t2_aref_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_AREF});
    check("t2_aref_addr", {19'd0, sdram_addr}, 32'h00AA);
    check("t2_aref_ba", {30'd0, sdram_ba}, 32'd0);
    aref_req = 1'b0; aref_done = 1'b1;
    step();
    chk_nop("t2_gap1");
    aref_done = 1'b0;
    step();
    check("t2_wr_en", grants(), 32'b010);
    check("t2_wr_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_WR});
    check("t2_wr_addr", {19'd0, sdram_addr}, 32'h0111);
    check("t2_wr_ba", {30'd0, sdram_ba}, 32'd1);
    wr_done = 1'b1;
    step();
    chk_nop("t3_gap1");
    wr_done = 1'b0;
    step();
    check("t3_rd_en", grants(), 32'b001);
    check("t3_rd_addr", {19'd0, sdram_addr}, 32'h0222);
    check("t3_rd_ba", {30'd0, sdram_ba}, 32'd2);
    rd_done = 1'b1;
    step();
    chk_nop("t3_gap2");
    rd_done = 1'b0;
    step();
    check("t3_wr2_en", grants(), 32'b010);
    wr_done = 1'b1;
    step();
    chk_nop("t3_gap3");
    wr_done = 1'b0;
    step();
    check("t3_rd2_en", grants(), 32'b001);

    // Test 4: refresh waits for the active write; foreign done ignored.
    rd_done = 1'b1; rd_req = 1'b0;
    step();
    chk_nop("t4_gap");
    rd_done = 1'b0;
    step();
    check("t4_wr_en", grants(), 32'b010);
    aref_req = 1'b1;
    step();
    check("t4_hold1", grants(), 32'b010);
    rd_done = 1'b1;
    step();
    check("t4_hold2", grants(), 32'b010);
    rd_done = 1'b0; wr_done = 1'b1;
    step();
    chk_nop("t4_gap2");
    wr_done = 1'b0; wr_req = 1'b0;
    step();
    check("t4_aref_en", grants(), 32'b100);
    aref_req = 1'b0; aref_done = 1'b1;
    step();
    chk_nop("t4_gap3");
    aref_done = 1'b0;

    // Test 5: read grant without done is released after TIMEOUT cycles.
    rd_req = 1'b1;
    step();
    check("t5_rd_en0", grants(), 32'b001);
    rd_req = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      check("t5_rd_hold", grants(), 32'b001);
      check("t5_err_lo", {31'd0, arb_err}, 32'd0);
    end
    step();
    chk_nop("t5_release");
    check("t5_err_hi", {31'd0, arb_err}, 32'd1);
    step();
    check("t5_err_pulse", {31'd0, arb_err}, 32'd0);
    chk_nop("t5_idle");

    // Test 6: asynchronous reset in the middle of a write.
    wr_req = 1'b1;
    step();
    check("t6_wr_en", grants(), 32'b010);
    wr_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", grants(), 32'd0);
    check("t6_rst_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_PALL});
    check("t6_rst_addr", {19'd0, sdram_addr}, 32'h0400);
    init_cmd = CMD_MRS; init_addr = 13'h0033;
    #1;
    check("t6_follow_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_MRS});
    check("t6_follow_addr", {19'd0, sdram_addr}, 32'h0033);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_nop("t6_rearbit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
